// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes, memory-wait freezes.
// Define HAZARD_PERF_EN to build the stall_cycles/flush_cycles performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned LOAD_STALL  = 1,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_tk,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              mem_error,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles
);

    localparam int unsigned LU_CW   = 2;
    localparam int unsigned WAIT_CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LU_CW-1:0]   lu_cnt_q, lu_cnt_d;
    logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic               resume_lu_q, resume_lu_d;
    logic               mem_error_q, mem_error_d;

    logic lu, mw, in_lu_stall;

    assign lu = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mw = mem_req && !mem_ready;
    // A memory freeze taken during a load-use stall resumes the stall afterwards.
    assign in_lu_stall = (state_q == LU_STALL) || ((state_q == MEM_WAIT) && resume_lu_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            lu_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            resume_lu_q <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            resume_lu_q <= resume_lu_d;
            mem_error_q <= mem_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        resume_lu_d = resume_lu_q;
        mem_error_d = mem_error_q;
        wait_inc    = (wait_cnt_q == WAIT_CW'(MEM_TIMEOUT)) ? wait_cnt_q
                                                            : WAIT_CW'(wait_cnt_q + WAIT_CW'(1));
        if (mw) begin
            if (state_q == MEM_WAIT) begin
                wait_cnt_d = wait_inc;
                if (wait_inc == WAIT_CW'(MEM_TIMEOUT)) begin
                    mem_error_d = 1'b1;
                end
            end else begin
                state_d     = MEM_WAIT;
                wait_cnt_d  = WAIT_CW'(1);
                resume_lu_d = (state_q == LU_STALL);
            end
        end else if (in_lu_stall) begin
            lu_cnt_d = LU_CW'(lu_cnt_q - LU_CW'(1));
            state_d  = (lu_cnt_q == LU_CW'(1)) ? RUN : LU_STALL;
        end else if (ex_branch_tk) begin
            state_d = RUN;
        end else if (lu && (LOAD_STALL > 1)) begin
            state_d  = LU_STALL;
            lu_cnt_d = LU_CW'(LOAD_STALL - 1);
        end else begin
            state_d = RUN;
        end
    end

    // Enables and flush selects act on the pipeline registers in the same cycle.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!reset && !mw) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (in_lu_stall || (!ex_branch_tk && lu)) begin
                idex_flush = 1'b1;
            end else begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = ex_branch_tk;
                idex_flush = ex_branch_tk;
            end
        end
    end

    assign mem_error = mem_error_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ifid_flush || idex_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_STALL 1 and 3, MEM_TIMEOUT 8) against a bubble-count reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int TMO = 8;

    typedef struct packed {
        logic        pc, ifid, idex, exmem, memwb, fi, fx, err;
        logic [31:0] sc, fc;
    } obs_t;

    logic clk, reset;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic ex_memread, ex_branch_tk, mem_req, mem_ready;

    logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fi, a_fx, a_err;
    logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fi, b_fx, b_err;
    logic [31:0] a_sc, a_fc, b_sc, b_fc;

    pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(1), .MEM_TIMEOUT(TMO)) u_dut_s1 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_branch_tk(ex_branch_tk), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem), .memwb_en(a_memwb),
        .ifid_flush(a_fi), .idex_flush(a_fx), .mem_error(a_err), .stall_cycles(a_sc), .flush_cycles(a_fc));

    pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(3), .MEM_TIMEOUT(TMO)) u_dut_s3 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_branch_tk(ex_branch_tk), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem), .memwb_en(b_memwb),
        .ifid_flush(b_fi), .idex_flush(b_fx), .mem_error(b_err), .stall_cycles(b_sc), .flush_cycles(b_fc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one slot per controller
    int          m_bub[2];
    int          m_wait[2];
    bit          m_frz[2];
    bit          m_err[2];
    int unsigned m_sc[2];
    int unsigned m_fc[2];
    int          m_ls[2] = '{1, 3};

    obs_t exp_q0[$];
    obs_t exp_q1[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic model_step(input int k, output obs_t o);
        bit mw, lu;
        o = '0;
        if (reset) begin
            m_bub[k] = 0; m_wait[k] = 0; m_frz[k] = 0; m_err[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            return;
        end
        o.err = m_err[k];
        o.sc  = m_sc[k];
        o.fc  = m_fc[k];
        mw = mem_req && !mem_ready;
        lu = ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (mw) begin
            if (!m_frz[k]) begin
                m_frz[k] = 1; m_wait[k] = 1;
            end else begin
                if (m_wait[k] < TMO) m_wait[k]++;
                if (m_wait[k] == TMO) m_err[k] = 1;
            end
        end else begin
            m_frz[k] = 0;
            {o.idex, o.exmem, o.memwb} = 3'b111;
            if (m_bub[k] > 0) begin
                o.fx = 1; m_bub[k]--;
            end else if (ex_branch_tk) begin
                {o.pc, o.ifid, o.fi, o.fx} = 4'b1111;
            end else if (lu) begin
                o.fx = 1; m_bub[k] = m_ls[k] - 1;
            end else begin
                {o.pc, o.ifid} = 2'b11;
            end
        end
`ifdef HAZARD_PERF_EN
        if (!o.pc) m_sc[k]++;
        if (o.fi || o.fx) m_fc[k]++;
`endif
    endtask

    task automatic drive(input bit r, input int rs1, input int rs2, input int rd,
                         input bit mr, input bit br, input bit req, input bit rdy);
        obs_t e0, e1;
        @(posedge clk);
        #1;
        reset = r; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); ex_rd = AW'(rd);
        ex_memread = mr; ex_branch_tk = br; mem_req = req; mem_ready = rdy;
        model_step(0, e0);
        model_step(1, e1);
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
    endtask

    task automatic check(input string nm, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got en=%b fl=%b err=%b sc=%0d fc=%0d, required en=%b fl=%b err=%b sc=%0d fc=%0d",
                     nm, $time, {got.pc, got.ifid, got.idex, got.exmem, got.memwb}, {got.fi, got.fx}, got.err,
                     got.sc, got.fc, {exp.pc, exp.ifid, exp.idex, exp.exmem, exp.memwb}, {exp.fi, exp.fx},
                     exp.err, exp.sc, exp.fc);
        end
    endtask

    // Monitor: outputs are valid every cycle once a vector has been applied
    always @(negedge clk) begin
        obs_t ga, gb;
        ga = '{a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fi, a_fx, a_err, a_sc, a_fc};
        gb = '{b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fi, b_fx, b_err, b_sc, b_fc};
        if (exp_q0.size() > 0) check("ls1", ga, exp_q0.pop_front());
        if (exp_q1.size() > 0) check("ls3", gb, exp_q1.pop_front());
    end

    initial begin
        reset = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_memread = 1'b0; ex_branch_tk = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        repeat (2) drive(1, 5, 5, 5, 1, 1, 1, 0);         // outputs forced low in reset
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0, 0);         // idle run
        drive(0, 1, 5, 5, 1, 0, 0, 0);                    // load-use on rs2
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);                    // load to x0: no hazard
        drive(0, 3, 7, 3, 1, 1, 0, 0);                    // branch beats load-use
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 1, 0);         // memory wait
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 2, 0, 2, 1, 0, 0, 0);                    // load-use, then freeze mid-stall
        repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 1, 1);
        repeat (12) drive(0, 0, 0, 0, 0, 0, 1, 0);       // timeout, sticky error
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 4, 0, 4, 1, 0, 0, 0);                    // reset mid-stall
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(99) == 0,
                  int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
                  $urandom_range(99) < 40, $urandom_range(99) < 15,
                  $urandom_range(99) < 30, $urandom_range(99) < 60);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expected entries left, required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
